// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate and up/down count,
// updated on the falling clock edge, with async active-low reset and sync clear.
module universal_shift_reg #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_UP    = 3'b110,
        MODE_DOWN  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    mode_e            w_mode;

    assign w_mode = mode_e'(mode);

    always_comb begin
        // NOTE: default assigned first so every path drives w_q_next; no latch.
        w_q_next = r_q;
        if (clr) begin
            w_q_next = '0;
        end else if (en) begin
            case (w_mode)
                MODE_HOLD: w_q_next = r_q;
                MODE_LOAD: w_q_next = d;
                MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], sin};
                MODE_SHR:  w_q_next = {sin, r_q[WIDTH-1:1]};
                MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                MODE_UP:   w_q_next = r_q + ONE;
                MODE_DOWN: w_q_next = r_q - ONE;
                default:   w_q_next = r_q;
            endcase
        end
    end

    // Storage element triggers on the falling edge; reset is independent of clk.
    always_ff @(negedge clk or negedge rst) begin
        // NOTE: non-blocking assignment for registered state.
        if (!rst) begin
            r_q <= RST_Q;
        end else begin
            r_q <= w_q_next;
        end
    end

    always_comb begin
        sout = 1'b0;
        case (w_mode)
            MODE_SHL, MODE_ROL: sout = r_q[WIDTH-1];
            MODE_SHR, MODE_ROR: sout = r_q[0];
            default:            sout = 1'b0;
        endcase
    end

    // Terminal count looks only at q and mode, so it previews the wrap ahead of the edge.
    assign tc   = ((w_mode == MODE_UP)   && (&r_q)) ||
                  ((w_mode == MODE_DOWN) && (r_q == '0));
    assign zero = (r_q == '0);
    assign q    = r_q;

endmodule
